// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   state_t   : bus FSM states
//   owner_t   : which requester owns the transaction in flight
//   DEF_*     : default starvation limit and bus watchdog limit
//   WAIT_W/WD_W : widths sized for the legal parameter ranges
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam int DEF_MAX_WAIT = 4;
  localparam int DEF_TIMEOUT  = 255;

  // MAX_WAIT is 1..15, TIMEOUT is 1..255.
  localparam int WAIT_W = 4;
  localparam int WD_W   = 8;

endpackage

// File: rtl/arb_prio.sv
// Grant selection for the two requesters plus the fetch starvation counter.
//   en      : arbiter may grant this cycle (FSM is idle)
//   if_req  : fetch request          if_gnt : fetch granted
//   dm_req  : data request           dm_gnt : data granted
// Data wins by default; once fetch has lost MAX_WAIT grants in a row while
// requesting, fetch wins the next grant.
module arb_prio
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic if_req,
  input  logic dm_req,
  output logic if_gnt,
  output logic dm_gnt
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;
  logic              starve;

  assign starve = (wait_cnt == WAIT_LIMIT) && if_req;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves a value unassigned and infers a latch.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (en) begin
      if_gnt = if_req && (!dm_req || starve);
      dm_gnt = dm_req && !starve;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wait_cnt <= '0;
    end else if (if_gnt) begin
      wait_cnt <= '0;
    end else if (dm_gnt && if_req && (wait_cnt != WAIT_LIMIT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between instruction fetch (if_*) and
// data access (dm_*).
//   if_req/if_addr -> if_gnt, completion if_rvalid/if_rdata/if_err
//   dm_req/we/addr/wdata/wstrb -> dm_gnt, completion dm_rvalid/dm_rdata/dm_err
//   bus_req/we/addr/wdata/wstrb -> external bus, bus_ack/bus_rdata back
//   busy : a transaction is outstanding
// Flow: grant in IDLE, hold bus_req in BUS until ack or watchdog expiry,
// pulse the owner's rvalid in DONE, return to IDLE.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  output logic            if_err,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  input  logic [DW/8-1:0] dm_wstrb,
  output logic            dm_gnt,
  output logic            dm_rvalid,
  output logic [DW-1:0]   dm_rdata,
  output logic            dm_err,
  output logic            bus_req,
  output logic            bus_we,
  output logic [AW-1:0]   bus_addr,
  output logic [DW-1:0]   bus_wdata,
  output logic [DW/8-1:0] bus_wstrb,
  input  logic            bus_ack,
  input  logic [DW-1:0]   bus_rdata,
  output logic            busy
);

  // Last watchdog value before expiry: expiry lands on the TIMEOUT-th BUS cycle.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  owner_t          owner_q;
  logic [WD_W-1:0] wd_q;
  logic            wd_expired;
  logic [DW-1:0]   if_rdata_q, dm_rdata_q;
  logic            if_err_q, dm_err_q;

  arb_prio #(
    .MAX_WAIT (MAX_WAIT)
  ) u_arb_prio (
    .clk    (clk),
    .nrst   (nrst),
    .en     (state_q == IDLE),
    .if_req (if_req),
    .dm_req (dm_req),
    .if_gnt (if_gnt),
    .dm_gnt (dm_gnt)
  );

  assign wd_expired = (wd_q == WD_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (if_gnt || dm_gnt) state_d = BUS;
      BUS:     if (bus_ack || wd_expired) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request fields are captured only on a grant and stay stable through BUS.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      owner_q   <= OWN_IF;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
    end else if (if_gnt) begin
      owner_q   <= OWN_IF;
      bus_we    <= 1'b0;
      bus_addr  <= if_addr;
      bus_wdata <= '0;
      bus_wstrb <= '1;
    end else if (dm_gnt) begin
      owner_q   <= OWN_DM;
      bus_we    <= dm_we;
      bus_addr  <= dm_addr;
      bus_wdata <= dm_wdata;
      bus_wstrb <= dm_wstrb;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wd_q <= '0;
    end else if (state_q == BUS) begin
      wd_q <= wd_q + 1'b1;
    end else begin
      wd_q <= '0;
    end
  end

  // Completion data per side; ack takes precedence over a simultaneous expiry.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      if_rdata_q <= '0;
      if_err_q   <= 1'b0;
      dm_rdata_q <= '0;
      dm_err_q   <= 1'b0;
    end else if (state_q == BUS && (bus_ack || wd_expired)) begin
      if (owner_q == OWN_IF) begin
        if_rdata_q <= bus_ack ? bus_rdata : '0;
        if_err_q   <= !bus_ack;
      end else begin
        dm_rdata_q <= (bus_ack && !bus_we) ? bus_rdata : '0;
        dm_err_q   <= !bus_ack;
      end
    end
  end

  assign bus_req   = (state_q == BUS);
  assign busy      = (state_q != IDLE);
  assign if_rvalid = (state_q == DONE) && (owner_q == OWN_IF);
  assign dm_rvalid = (state_q == DONE) && (owner_q == OWN_DM);
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_err    = dm_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (MAX_WAIT=4, TIMEOUT=8).
// Stimulus pushes expected bus transfers and completions into queues; a bus
// responder and a completion monitor pop and compare independently.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    bit          dm;
    logic [31:0] rdata;
    bit          err;
  } cpl_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_t;

  logic          clk = 1'b0;
  logic          nrst;
  logic          if_req, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [3:0]    dm_wstrb;
  logic          if_gnt, if_rvalid, if_err, dm_gnt, dm_rvalid, dm_err;
  logic [DW-1:0] if_rdata, dm_rdata;
  logic          bus_req, bus_we, bus_ack, busy;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;
  logic [3:0]    bus_wstrb;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  cpl_t cpl_q[$];
  bus_t bus_q[$];

  int          ack_lat = 1;   // ack on this BUS cycle (1-based); 0 = never
  logic [31:0] ack_data = '0;
  int          bus_cnt = 0;
  int          last_bus_cyc = 0;
  int          last_bus_len = 0;

  mem_port_arbiter #(
    .AW (AW), .DW (DW), .MAX_WAIT (4), .TIMEOUT (8)
  ) dut (
    .clk (clk), .nrst (nrst),
    .if_req (if_req), .if_addr (if_addr), .if_gnt (if_gnt),
    .if_rvalid (if_rvalid), .if_rdata (if_rdata), .if_err (if_err),
    .dm_req (dm_req), .dm_we (dm_we), .dm_addr (dm_addr),
    .dm_wdata (dm_wdata), .dm_wstrb (dm_wstrb), .dm_gnt (dm_gnt),
    .dm_rvalid (dm_rvalid), .dm_rdata (dm_rdata), .dm_err (dm_err),
    .bus_req (bus_req), .bus_we (bus_we), .bus_addr (bus_addr),
    .bus_wdata (bus_wdata), .bus_wstrb (bus_wstrb),
    .bus_ack (bus_ack), .bus_rdata (bus_rdata), .busy (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus responder: checks the captured fields on the first BUS cycle, then
  // acknowledges on the ack_lat-th cycle.
  initial begin
    bus_t e;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus_req) begin
        if (bus_cnt == 0) begin
          if (bus_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_bus_req at cycle %0d", cyc);
          end else begin
            e = bus_q.pop_front();
            check("bus_we", bus_we, e.we);
            check("bus_addr", bus_addr, e.addr);
            check("bus_wstrb", bus_wstrb, e.wstrb);
            if (e.we) check("bus_wdata", bus_wdata, e.wdata);
          end
        end
        bus_cnt++;
        last_bus_cyc = cyc;
        bus_ack   = (ack_lat != 0) && (bus_cnt == ack_lat);
        bus_rdata = bus_ack ? ack_data : 32'hBAD0_BAD0;
      end else begin
        if (bus_cnt != 0) last_bus_len = bus_cnt;
        bus_cnt   = 0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
      end
    end
  end

  // Completion monitor.
  initial begin
    cpl_t e;
    forever begin
      @(negedge clk);
      if (nrst && (if_rvalid || dm_rvalid)) begin
        check("rvalid_onehot", if_rvalid & dm_rvalid, 0);
        if (cpl_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_rvalid if=%0b dm=%0b at cycle %0d", if_rvalid, dm_rvalid, cyc);
        end else begin
          e = cpl_q.pop_front();
          check("cpl_owner_dm", dm_rvalid, e.dm);
          check("cpl_rdata", e.dm ? dm_rdata : if_rdata, e.rdata);
          check("cpl_err", e.dm ? dm_err : if_err, e.err);
          check("cpl_latency", cyc, last_bus_cyc + 1);
        end
      end
    end
  end

  task automatic wait_done(input string name);
    for (int i = 0; i < 40 && cpl_q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (cpl_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_completion_timeout pending=%0d", name, cpl_q.size());
      cpl_q.delete();
    end
    @(posedge clk);
    #1;
    check({name, "_idle_busy"}, busy, 0);
  endtask

  task automatic do_req(input string name, input bit dm, input bit we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int lat,
                        input logic [31:0] data, input bit exp_err);
    bus_t b;
    cpl_t c;
    bit   got;
    int   waited;
    ack_lat  = lat;
    ack_data = data;
    b.we    = we;
    b.addr  = addr;
    b.wdata = wdata;
    b.wstrb = dm ? wstrb : 4'hF;
    bus_q.push_back(b);
    c.dm    = dm;
    c.rdata = (we || exp_err) ? 32'h0 : data;
    c.err   = exp_err;
    cpl_q.push_back(c);
    @(posedge clk);
    #1;
    if (dm) begin
      dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata; dm_wstrb = wstrb;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    got = 1'b0;
    waited = 0;
    while (!got && waited < 20) begin
      @(negedge clk);
      waited++;
      got = dm ? dm_gnt : if_gnt;
    end
    check({name, "_gnt"}, got, 1);
    check({name, "_gnt_cycle"}, waited, 1);
    check({name, "_other_gnt"}, dm ? if_gnt : dm_gnt, 0);
    @(posedge clk);
    #1;
    if_req = 1'b0;
    dm_req = 1'b0;
    wait_done(name);
  endtask

  initial begin
    bit   ord [6];
    int   ng;
    bus_t b;
    cpl_t c;

    ord[0] = 1; ord[1] = 1; ord[2] = 1; ord[3] = 1; ord[4] = 0; ord[5] = 1;

    nrst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
    #23;
    check("rst_bus_req", bus_req, 0);
    check("rst_busy", busy, 0);
    check("rst_if_rvalid", if_rvalid, 0);
    check("rst_dm_rvalid", dm_rvalid, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wstrb", bus_wstrb, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_err", dm_err, 0);
    @(posedge clk);
    #2;
    nrst = 1'b1;

    // Single fetch, ack on the third BUS cycle.
    do_req("fetch", 0, 0, 32'h40, 32'h0, 4'h0, 3, 32'h00A0_0093, 0);

    // Data write, immediate ack: rdata must read back 0.
    do_req("write", 1, 1, 32'h100, 32'hDEAD_BEEF, 4'h3, 1, 32'h5555_AAAA, 0);

    // Data read with nonzero data.
    do_req("read", 1, 0, 32'h104, 32'h0, 4'hF, 2, 32'hCAFE_F00D, 0);

    // Contention: both requesters held, grant order DM x4, IF, DM.
    ack_lat  = 1;
    ack_data = 32'h0000_1111;
    @(posedge clk);
    #1;
    if_req = 1'b1; if_addr = 32'h80;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; dm_wstrb = 4'hF;
    ng = 0;
    for (int i = 0; i < 80 && ng < 6; i++) begin
      @(negedge clk);
      if (if_gnt || dm_gnt) begin
        check("cont_one_gnt", if_gnt & dm_gnt, 0);
        check("cont_order_dm", dm_gnt, ord[ng]);
        b.we    = 1'b0;
        b.addr  = ord[ng] ? 32'h300 : 32'h80;
        b.wdata = 32'h0;
        b.wstrb = 4'hF;
        bus_q.push_back(b);
        c.dm    = ord[ng];
        c.rdata = 32'h0000_1111;
        c.err   = 1'b0;
        cpl_q.push_back(c);
        ng++;
      end
    end
    check("cont_grant_count", ng, 6);
    @(posedge clk);
    #1;
    if_req = 1'b0;
    dm_req = 1'b0;
    wait_done("cont");

    // Watchdog expiry: no ack, bus_req held exactly 8 cycles.
    do_req("timeout", 1, 0, 32'h200, 32'h0, 4'hF, 0, 32'h0, 1);
    check("timeout_bus_len", last_bus_len, 8);

    // Ack on the expiry cycle: normal completion.
    do_req("ack_at_expiry", 0, 0, 32'h48, 32'h0, 4'h0, 8, 32'h1234_5678, 0);
    check("ack_at_expiry_bus_len", last_bus_len, 8);

    // Fetch after an error completion clears if_err.
    do_req("fetch_after", 0, 0, 32'h4C, 32'h0, 4'h0, 1, 32'h0000_0013, 0);

    // Reset during BUS: transfer abandoned, no completion.
    ack_lat = 0;
    b.we = 1'b0; b.addr = 32'h400; b.wdata = 32'h0; b.wstrb = 4'hF;
    bus_q.push_back(b);
    @(posedge clk);
    #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400; dm_wstrb = 4'hF;
    @(negedge clk);
    check("rst_mid_gnt", dm_gnt, 1);
    @(posedge clk);
    #1;
    dm_req = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("rst_mid_pre_bus_req", bus_req, 1);
    nrst = 1'b0;
    #1;
    check("rst_mid_bus_req", bus_req, 0);
    check("rst_mid_busy", busy, 0);
    repeat (2) @(posedge clk);
    #2;
    nrst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_mid_no_rvalid", dm_rvalid | if_rvalid, 0);

    do_req("post_reset", 1, 0, 32'h404, 32'h0, 4'hF, 1, 32'h0BAD_CAFE, 0);

    check("bus_q_empty", bus_q.size(), 0);
    check("cpl_q_empty", cpl_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one external single-port memory bus between the instruction-fetch side (ins_mod) and the data side (dmem_mod) of the 3-stage core. Requests are accepted through a req/gnt handshake and completed with a one-cycle rvalid pulse. Data requests have priority, and a starvation counter guarantees fetch progress. A bus watchdog converts a missing acknowledge into an error completion.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_WAIT, 4, consecutive fetch-losing grants before fetch is forced to win once (1..15)
TIMEOUT, 255, cycles without bus_ack before error completion (1..255)

Ports:
clk  in  1  system clock, rising edge
nrst  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held until if_gnt
if_addr  in  AW  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  one-cycle fetch completion pulse
if_rdata  out  DW  fetched word, valid with if_rvalid
if_err  out  1  fetch timed out, valid with if_rvalid
dm_req  in  1  data request, held until dm_gnt
dm_we  in  1  1 = write, 0 = read
dm_addr  in  AW  data address
dm_wdata  in  DW  write data
dm_wstrb  in  DW/8  byte enables for writes
dm_gnt  out  1  data request accepted this cycle
dm_rvalid  out  1  one-cycle data completion pulse (reads and writes)
dm_rdata  out  DW  read data, valid with dm_rvalid (0 for writes)
dm_err  out  1  data access timed out, valid with dm_rvalid
bus_req  out  1  external bus request, held until bus_ack
bus_we  out  1  external write enable
bus_addr  out  AW  external address
bus_wdata  out  DW  external write data
bus_wstrb  out  DW/8  external byte enables (all-ones for fetch)
bus_ack  in  1  external transfer done; read data valid same cycle
bus_rdata  in  DW  external read data
busy  out  1  transaction outstanding (for core stall logic)

Behaviour:
- Reset (async, nrst=0): state IDLE. All outputs 0. Wait counter and watchdog cleared. Any in-flight transfer is abandoned with no completion; bus_req drops immediately.
- FSM states: IDLE, BUS, DONE.
- IDLE: grants are combinational from req and the wait counter. dm wins if dm_req, unless wait_cnt == MAX_WAIT and if_req, in which case if wins. Exactly one gnt is high per cycle. The granted request's fields are latched into the bus_* registers at the clock edge, and owner is recorded. Next state is BUS.
- wait_cnt: increments when dm is granted while if_req=1 (saturates at MAX_WAIT). Clears when if is granted.
- BUS: bus_req=1, with bus_* fields stable throughout. The watchdog counts cycles spent in BUS.
  - bus_ack=1: capture bus_rdata (reads only; writes capture 0), go to DONE.
  - Watchdog reaches TIMEOUT with no ack: rdata=0, err=1, go to DONE.
  - bus_ack in the same cycle as the timeout: ack wins, no error.
- DONE: owner's rvalid=1 for exactly this cycle, with rdata/err valid. bus_req=0. No grant is issued in DONE. Next state is IDLE.
- Latency: gnt in cycle 0, bus_req from cycle 1, ack in cycle k≥1, rvalid in cycle k+1. Minimum request-to-request spacing is 3 cycles.
- busy = (state != IDLE).
- rdata/err hold their value outside rvalid until the next completion.
- A requester dropping req before gnt is legal; nothing is latched.
- Inputs are ignored outside IDLE.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, BUS, DONE}
  - owner encoding {OWN_IF, OWN_DM}
  - default MAX_WAIT/TIMEOUT constants
- One sub-module, arb_prio: combinational grant selection plus the saturating wait counter register. The FSM, bus registers and watchdog stay in the top module.

Test Plan:
- Single fetch: if_req, addr 0x40, bus_ack 2 cycles after bus_req with rdata 0x00A00093 → if_gnt cycle 0, bus_addr 0x40, bus_wstrb 0xF, if_rvalid with rdata 0x00A00093, err 0, 1 cycle after ack.
- Data write: dm_we=1, addr 0x100, wdata 0xDEADBEEF, wstrb 0x3, immediate ack → bus_we=1 with those values, dm_rvalid pulse, dm_rdata 0.
- Contention with MAX_WAIT=4: if_req and dm_req held continuously → grant order DM, DM, DM, DM, IF, DM…; fetch is never starved beyond 4 grants.
- Timeout with TIMEOUT=8 and no ack → bus_req high exactly 8 cycles, then dm_rvalid with dm_err=1, dm_rdata 0, state returns to IDLE.
- Ack on the watchdog expiry cycle → normal completion, err=0.
- nrst low during BUS → bus_req and busy 0 asynchronously, no rvalid afterward; the next request after reset completes normally.
